logic_ex_sync: RTL and testbench
================================

Name: logic_ex_sync

Overview:
Maps two slide switches to four LEDs through fixed Boolean functions: NOT, AND-NOT, OR and XOR. The switch inputs are asynchronous to `clk`, so they are synchronized, optionally debounced, decoded, and driven out on registered LEDs. The block sits at board top level, directly between the switch pins and the LED pins.

Parameters:
SYNC_STAGES, 2, number of flip-flop stages in the SW synchronizer (legal range 2..4).
DEBOUNCE_CYCLES, 0, consecutive stable clock cycles required before a synchronized SW value is accepted; 0 disables debouncing.

Ports:
clk  input  1  system clock; every register is on its rising edge.
rst  input  1  reset, synchronous, active-high.
SW  input  2  raw switch inputs, asynchronous to clk.
LED  output  4  registered LED drive, 1 = LED on.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. All state updates happen only on the rising edge of clk.
- Reset, while rst=1 at a clk edge:
  - every synchronizer stage is cleared to 2'b00;
  - the debounce counter is cleared to 0;
  - the accepted switch value sw_q is cleared to 2'b00;
  - LED is cleared to 4'b0000. This is deliberately not the decode of 00, so reset is visible on the LEDs.
- Synchronizer: SW passes through a chain of SYNC_STAGES flops; sw_sync is the last stage. No logic sits between the stages.
- Debounce with DEBOUNCE_CYCLES=0: sw_q <= sw_sync every cycle.
- Debounce with DEBOUNCE_CYCLES=N>0:
  - a counter resets to 0 whenever sw_sync differs from its previous-cycle value, and otherwise increments, saturating at N;
  - sw_q <= sw_sync only in a cycle where the counter equals N;
  - a glitch shorter than N cycles never reaches sw_q.
- Decode, combinational from sw_q and registered into LED every cycle:
  - LED[0] = ~sw_q[0]
  - LED[1] = sw_q[1] & ~sw_q[0]
  - LED[2] = sw_q[1] | sw_q[0]
  - LED[3] = sw_q[1] ^ sw_q[0]
- Truth table, SW -> LED[3:0]: 00 -> 0001, 01 -> 1100, 10 -> 1111, 11 -> 0100.
- Latency with DEBOUNCE_CYCLES=0: a SW change that meets setup before edge k appears on LED after edge k+SYNC_STAGES+1. That is 4 edges at the default, so LED is valid on the 4th rising edge after the change.
- Latency with DEBOUNCE_CYCLES=N: N additional edges beyond the above, provided SW is held stable.
- Both SW bits changing together are treated as one new value. No intermediate LED pattern is required to appear or be suppressed unless debounce is enabled.
- Reset asserted mid-operation overrides everything on that edge. After release, LED shows the decode of the current SW once the full latency has elapsed again.
- No X propagation: LED is 0000 from the first reset edge onward.

Test Plan:
1. Reset: rst=1 for 2 edges with SW=10 -> LED=0000 during reset. Release -> LED=1111 exactly 4 edges after the release edge (defaults).
2. Exhaustive sweep: SW=00,01,10,11, each held 10 cycles -> LED settles to 0001, 1100, 1111, 0100 respectively, each within 4 edges of the change.
3. Latency: SW 00->11 just after an edge -> LED stays 0001 for 3 edges and becomes 0100 on the 4th.
4. Reset mid-operation: SW=01 with LED=1100, then assert rst for 1 edge -> LED=0000 on that edge. LED returns to 1100 after release plus 4 edges.
5. Debounce (DEBOUNCE_CYCLES=8): SW=00, pulse SW=01 for 3 cycles -> LED stays 0001. Then hold SW=01 -> LED=1100 after 4+8 edges.
6. Simultaneous change: SW 01->10 in one step -> LED goes from 1100 directly to 1111 with no other steady value held for longer than 1 cycle.

Source files
------------

// File: rtl/logic_ex_sync.sv
// Two slide switches to four LEDs: sync chain, optional debounce, fixed NOT/AND-NOT/OR/XOR decode.
// Latency SYNC_STAGES+2 edges (plus DEBOUNCE_CYCLES when enabled); no backpressure, LEDs update every cycle.
module logic_ex_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] SW,
  output logic [3:0] LED
);

  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic [1:0]                  sw_sync;
  logic [1:0]                  sw_q;
  logic [1:0]                  sw_d;
  logic [3:0]                  led_d;

  assign sw_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= SW;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodb
      assign sw_d = sw_sync;
    end else begin : g_db
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

      logic [1:0]    prev_q;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (sw_sync != prev_q) begin
          cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Accept on the edge where the count reaches N, so hold time adds exactly N edges.
      assign sw_d = (cnt_d == CNT_MAX) ? sw_sync : sw_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          prev_q <= 2'b00;
          cnt_q  <= '0;
        end else begin
          prev_q <= sw_sync;
          cnt_q  <= cnt_d;
        end
      end
    end
  endgenerate

  always_comb begin
    led_d    = 4'b0000;
    led_d[0] = ~sw_q[0];
    led_d[1] = sw_q[1] & ~sw_q[0];
    led_d[2] = sw_q[1] | sw_q[0];
    led_d[3] = sw_q[1] ^ sw_q[0];
  end

  // Reset drives LED to 0000 rather than decode(00) so reset is visible on the board.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q <= 2'b00;
      LED  <= 4'b0000;
    end else begin
      sw_q <= sw_d;
      LED  <= led_d;
    end
  end

endmodule

// File: tb/tb_logic_ex_sync.sv
// Bench for logic_ex_sync: default instance checked every cycle against a history model,
// debounce instance (N=8) checked at scheduled cycles; both through one scoreboard.
module tb_logic_ex_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sw_a = 2'b00;
  logic [1:0] sw_b = 2'b00;
  logic [3:0] led_a;
  logic [3:0] led_b;

  always #5 clk = ~clk;

  logic_ex_sync u_dut_a (
    .clk (clk),
    .rst (rst),
    .SW  (sw_a),
    .LED (led_a)
  );

  logic_ex_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(8)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .SW  (sw_b),
    .LED (led_b)
  );

  typedef struct {
    int         cyc;
    logic [3:0] exp;
  } exp_t;

  exp_t       q_a[$];
  exp_t       q_b[$];
  logic       rst_h[$];
  logic [1:0] sw_h[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  string      phase = "init";

  function automatic logic [3:0] ref_led(input logic [1:0] s);
    case (s)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b1100;
      2'b10:   return 4'b1111;
      default: return 4'b0100;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s cycle %0d: got %0b expected %0b", phase, tag, cyc, got, exp);
    end
  endtask

  task automatic push_b(input int c, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.exp = v;
    q_b.push_back(e);
  endtask

  // Expected LED of the default instance at edge t: 0000 while in reset, 0001 while the
  // cleared pipeline drains (3 edges), otherwise the decode of SW applied 3 edges earlier.
  task automatic step(input logic r, input logic [1:0] sa, input logic [1:0] sb);
    exp_t       e;
    logic [3:0] x;
    @(negedge clk);
    rst  = r;
    sw_a = sa;
    sw_b = sb;
    rst_h.push_back(r);
    sw_h.push_back(sa);
    if (r) begin
      x = 4'b0000;
    end else begin
      x = (cyc >= 3) ? ref_led(sw_h[cyc-3]) : 4'b0001;
      for (int i = 1; i <= 3; i++) begin
        if (cyc >= i && rst_h[cyc-i]) x = 4'b0001;
      end
    end
    e.cyc = cyc;
    e.exp = x;
    q_a.push_back(e);
    @(posedge clk);
    #1;
    while (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
      e = q_a.pop_front();
      chk("led_a", {28'd0, led_a}, {28'd0, e.exp});
    end
    while (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
      e = q_b.pop_front();
      chk("led_b", {28'd0, led_b}, {28'd0, e.exp});
    end
    cyc++;
  endtask

  initial begin
    int k;
    logic [1:0] pats [4];
    pats[0] = 2'b00;
    pats[1] = 2'b01;
    pats[2] = 2'b10;
    pats[3] = 2'b11;

    phase = "reset";
    repeat (2) step(1'b1, 2'b10, 2'b00);
    repeat (6) step(1'b0, 2'b10, 2'b00);

    phase = "sweep";
    for (int p = 0; p < 4; p++) begin
      repeat (10) step(1'b0, pats[p], 2'b00);
    end

    phase = "latency";
    repeat (6) step(1'b0, 2'b00, 2'b00);
    repeat (6) step(1'b0, 2'b11, 2'b00);

    phase = "mid_reset";
    repeat (6) step(1'b0, 2'b01, 2'b00);
    step(1'b1, 2'b01, 2'b00);
    repeat (8) step(1'b0, 2'b01, 2'b00);

    phase = "debounce";
    k = cyc;
    for (int i = 0; i < 16; i++) push_b(k + i, 4'b0001);
    repeat (3) step(1'b0, 2'b01, 2'b01);
    repeat (16) step(1'b0, 2'b01, 2'b00);
    k = cyc;
    push_b(k + 10, 4'b0001);
    for (int i = 11; i <= 14; i++) push_b(k + i, 4'b1100);
    repeat (15) step(1'b0, 2'b01, 2'b01);

    phase = "simultaneous";
    repeat (8) step(1'b0, 2'b10, 2'b01);

    phase = "drain";
    chk("sb_empty", 32'(q_a.size() + q_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
